// File: rtl/sync_debounce_edge_if.sv
// Bundle of the raw input and the conditioned outputs of the debouncer.
// The slave side is the debouncer itself; the master side is whoever
// supplies the raw input and consumes the clean level and edge pulses.
interface sync_debounce_edge_if;
    logic din_async;
    logic dout;
    logic dout_n;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (
        output din_async,
        input  dout,
        input  dout_n,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  din_async,
        output dout,
        output dout_n,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/sync_debounce_edge.sv
// Synchroniser + counter-based debouncer for a raw push-button/switch input.
// Produces a clean registered level, its complement (for a downstream set_n pin),
// one-cycle rise/fall pulses and a busy flag while a change is being qualified.
module sync_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    sync_debounce_edge_if.slave bus
);

    // Reject parameter values that would make the synchroniser or the
    // qualification counter meaningless.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("sync_debounce_edge: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("sync_debounce_edge: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          dout_n_q;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy_q, busy_d;

    // Plain shift-register synchroniser; bit 0 takes the raw input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], bus.din_async};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // Debouncer state, counter and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            dout_q   <= RESET_LEVEL;
            dout_n_q <= ~RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dout_n_q <= ~dout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive samples of the new level; any sample of the old level
    // during qualification is treated as bounce and discards the attempt.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HI;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!sync_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LO;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (sync_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    assign bus.dout       = dout_q;
    assign bus.dout_n     = dout_n_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: default build, a fast build
// (DEBOUNCE_CYCLES=1, SYNC_STAGES=3) and a RESET_LEVEL=1 build.
module tb_sync_debounce_edge;

    logic clk;
    logic rst_n_a, rst_n_b, rst_n_c;
    int   checks;
    int   errors;

    sync_debounce_edge_if if_a ();
    sync_debounce_edge_if if_b ();
    sync_debounce_edge_if if_c ();

    sync_debounce_edge u_a (
        .clk     (clk),
        .reset_n (rst_n_a),
        .bus     (if_a.slave)
    );

    sync_debounce_edge #(
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1),
        .RESET_LEVEL     (1'b0)
    ) u_b (
        .clk     (clk),
        .reset_n (rst_n_b),
        .bus     (if_b.slave)
    );

    sync_debounce_edge #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .RESET_LEVEL     (1'b1)
    ) u_c (
        .clk     (clk),
        .reset_n (rst_n_c),
        .bus     (if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (if_a.dout !== 1'b0) begin errors++; $display("FAIL reset_a_dout got %b exp 0", if_a.dout); end
        checks++; if (if_a.dout_n !== 1'b1) begin errors++; $display("FAIL reset_a_dout_n got %b exp 1", if_a.dout_n); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %b exp 0", if_a.busy); end
        checks++; if (if_a.rise_pulse !== 1'b0 || if_a.fall_pulse !== 1'b0) begin errors++; $display("FAIL reset_a_pulses got %b%b exp 00", if_a.rise_pulse, if_a.fall_pulse); end
        checks++; if (if_b.dout !== 1'b0 || if_b.dout_n !== 1'b1) begin errors++; $display("FAIL reset_b_dout got %b/%b exp 0/1", if_b.dout, if_b.dout_n); end
        tick;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (4) tick;
        $display("reset: released a,b dout_a=%b dout_b=%b", if_a.dout, if_b.dout);
    endtask

    // Input high for 5 cycles only: must be rejected as bounce.
    task automatic test_glitch;
        for (int e = 0; e <= 25; e++) begin
            if (e == 0) if_a.din_async = 1'b1;
            if (e == 5) if_a.din_async = 1'b0;
            tick;
            checks++; if (if_a.busy !== ((e >= 2) && (e <= 6))) begin errors++; $display("FAIL glitch_busy edge %0d got %b exp %b", e, if_a.busy, ((e >= 2) && (e <= 6))); end
            checks++; if (if_a.dout !== 1'b0 || if_a.rise_pulse !== 1'b0 || if_a.fall_pulse !== 1'b0) begin errors++; $display("FAIL glitch_out edge %0d got dout=%b rise=%b fall=%b exp 0 0 0", e, if_a.dout, if_a.rise_pulse, if_a.fall_pulse); end
            $display("glitch: edge %0d busy=%b dout=%b", e, if_a.busy, if_a.dout);
        end
    endtask

    // Clean 0->1 step: busy after edge 2, dout and rise after edge 17.
    task automatic test_rise;
        for (int e = 0; e <= 18; e++) begin
            if (e == 0) if_a.din_async = 1'b1;
            tick;
            checks++; if (if_a.busy !== ((e >= 2) && (e <= 16))) begin errors++; $display("FAIL rise_busy edge %0d got %b exp %b", e, if_a.busy, ((e >= 2) && (e <= 16))); end
            checks++; if (if_a.dout !== (e >= 17)) begin errors++; $display("FAIL rise_dout edge %0d got %b exp %b", e, if_a.dout, (e >= 17)); end
            checks++; if (if_a.dout_n !== (e < 17)) begin errors++; $display("FAIL rise_dout_n edge %0d got %b exp %b", e, if_a.dout_n, (e < 17)); end
            checks++; if (if_a.rise_pulse !== (e == 17) || if_a.fall_pulse !== 1'b0) begin errors++; $display("FAIL rise_pulse edge %0d got rise=%b fall=%b exp %b 0", e, if_a.rise_pulse, if_a.fall_pulse, (e == 17)); end
            $display("rise: edge %0d busy=%b dout=%b rise=%b", e, if_a.busy, if_a.dout, if_a.rise_pulse);
        end
    endtask

    // 1->0 step with three 4-cycle bounces before the final settled low.
    task automatic test_bounce_fall;
        int fall_count;
        fall_count = 0;
        for (int b = 0; b < 3; b++) begin
            for (int p = 0; p < 8; p++) begin
                if_a.din_async = (p >= 4);
                tick;
                if (if_a.fall_pulse === 1'b1) fall_count++;
                checks++; if (if_a.dout !== 1'b1 || if_a.fall_pulse !== 1'b0) begin errors++; $display("FAIL bounce_hold b%0d p%0d got dout=%b fall=%b exp 1 0", b, p, if_a.dout, if_a.fall_pulse); end
            end
            $display("bounce: burst %0d done dout=%b", b, if_a.dout);
        end
        for (int e = 0; e <= 18; e++) begin
            if (e == 0) if_a.din_async = 1'b0;
            tick;
            if (if_a.fall_pulse === 1'b1) fall_count++;
            checks++; if (if_a.fall_pulse !== (e == 17)) begin errors++; $display("FAIL bounce_fall edge %0d got %b exp %b", e, if_a.fall_pulse, (e == 17)); end
            checks++; if (if_a.dout !== (e < 17)) begin errors++; $display("FAIL bounce_dout edge %0d got %b exp %b", e, if_a.dout, (e < 17)); end
            $display("bounce: settle edge %0d dout=%b fall=%b", e, if_a.dout, if_a.fall_pulse);
        end
        checks++; if (fall_count != 1) begin errors++; $display("FAIL bounce_fall_count got %0d exp 1", fall_count); end
    endtask

    // Reset asserted while qualifying a rise with cnt=10.
    task automatic test_reset_mid_wait;
        for (int e = 0; e <= 11; e++) begin
            if (e == 0) if_a.din_async = 1'b1;
            tick;
        end
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL midwait_busy_before got %b exp 1", if_a.busy); end
        #2;
        rst_n_a = 1'b0;
        #1;
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL midwait_async_busy got %b exp 0", if_a.busy); end
        checks++; if (if_a.dout !== 1'b0 || if_a.dout_n !== 1'b1) begin errors++; $display("FAIL midwait_async_dout got %b/%b exp 0/1", if_a.dout, if_a.dout_n); end
        checks++; if (if_a.rise_pulse !== 1'b0 || if_a.fall_pulse !== 1'b0) begin errors++; $display("FAIL midwait_async_pulses got %b%b exp 00", if_a.rise_pulse, if_a.fall_pulse); end
        $display("midwait: reset asserted busy=%b dout=%b", if_a.busy, if_a.dout);
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (if_a.rise_pulse !== 1'b0 || if_a.busy !== 1'b0) begin errors++; $display("FAIL midwait_in_reset cycle %0d got rise=%b busy=%b exp 0 0", i, if_a.rise_pulse, if_a.busy); end
        end
        rst_n_a = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            tick;
            checks++; if (if_a.rise_pulse !== (e == 17)) begin errors++; $display("FAIL midwait_rise edge %0d got %b exp %b", e, if_a.rise_pulse, (e == 17)); end
            checks++; if (if_a.busy !== ((e >= 2) && (e <= 16))) begin errors++; $display("FAIL midwait_busy edge %0d got %b exp %b", e, if_a.busy, ((e >= 2) && (e <= 16))); end
            $display("midwait: edge %0d busy=%b rise=%b", e, if_a.busy, if_a.rise_pulse);
        end
    endtask

    // Toggle reaching the synchroniser output on the acceptance edge.
    task automatic test_back_to_back;
        for (int e = 0; e <= 34; e++) begin
            if (e == 0)  if_a.din_async = 1'b0;
            if (e == 16) if_a.din_async = 1'b1;
            tick;
            checks++; if (if_a.fall_pulse !== (e == 17) || if_a.rise_pulse !== (e == 33)) begin errors++; $display("FAIL b2b_pulses edge %0d got rise=%b fall=%b exp %b %b", e, if_a.rise_pulse, if_a.fall_pulse, (e == 33), (e == 17)); end
            checks++; if (if_a.dout !== ((e < 17) || (e >= 33))) begin errors++; $display("FAIL b2b_dout edge %0d got %b exp %b", e, if_a.dout, ((e < 17) || (e >= 33))); end
            checks++; if (if_a.busy !== (((e >= 2) && (e <= 16)) || ((e >= 18) && (e <= 32)))) begin errors++; $display("FAIL b2b_busy edge %0d got %b exp %b", e, if_a.busy, (((e >= 2) && (e <= 16)) || ((e >= 18) && (e <= 32)))); end
            $display("b2b: edge %0d busy=%b dout=%b rise=%b fall=%b", e, if_a.busy, if_a.dout, if_a.rise_pulse, if_a.fall_pulse);
        end
    endtask

    // DEBOUNCE_CYCLES=1, SYNC_STAGES=3: accept on edge 3.
    task automatic test_fast;
        for (int e = 0; e <= 5; e++) begin
            if (e == 0) if_b.din_async = 1'b1;
            tick;
            checks++; if (if_b.dout !== (e >= 3) || if_b.dout_n !== (e < 3)) begin errors++; $display("FAIL fast_rise_dout edge %0d got %b/%b exp %b", e, if_b.dout, if_b.dout_n, (e >= 3)); end
            checks++; if (if_b.rise_pulse !== (e == 3) || if_b.busy !== 1'b0) begin errors++; $display("FAIL fast_rise_pulse edge %0d got rise=%b busy=%b exp %b 0", e, if_b.rise_pulse, if_b.busy, (e == 3)); end
            $display("fast: rise edge %0d dout=%b rise=%b", e, if_b.dout, if_b.rise_pulse);
        end
        for (int e = 0; e <= 5; e++) begin
            if (e == 0) if_b.din_async = 1'b0;
            tick;
            checks++; if (if_b.dout !== (e < 3)) begin errors++; $display("FAIL fast_fall_dout edge %0d got %b exp %b", e, if_b.dout, (e < 3)); end
            checks++; if (if_b.fall_pulse !== (e == 3) || if_b.rise_pulse !== 1'b0) begin errors++; $display("FAIL fast_fall_pulse edge %0d got fall=%b rise=%b exp %b 0", e, if_b.fall_pulse, if_b.rise_pulse, (e == 3)); end
            $display("fast: fall edge %0d dout=%b fall=%b", e, if_b.dout, if_b.fall_pulse);
        end
    endtask

    // RESET_LEVEL=1 with the input held low through reset release.
    task automatic test_reset_level_high;
        checks++; if (if_c.dout !== 1'b1 || if_c.dout_n !== 1'b0) begin errors++; $display("FAIL rl1_reset_dout got %b/%b exp 1/0", if_c.dout, if_c.dout_n); end
        checks++; if (if_c.busy !== 1'b0 || if_c.fall_pulse !== 1'b0 || if_c.rise_pulse !== 1'b0) begin errors++; $display("FAIL rl1_reset_flags got busy=%b fall=%b rise=%b exp 0 0 0", if_c.busy, if_c.fall_pulse, if_c.rise_pulse); end
        rst_n_c = 1'b1;
        #1;
        checks++; if (if_c.dout !== 1'b1) begin errors++; $display("FAIL rl1_release_dout got %b exp 1", if_c.dout); end
        for (int e = 0; e <= 18; e++) begin
            tick;
            checks++; if (if_c.fall_pulse !== (e == 17) || if_c.rise_pulse !== 1'b0) begin errors++; $display("FAIL rl1_fall edge %0d got fall=%b rise=%b exp %b 0", e, if_c.fall_pulse, if_c.rise_pulse, (e == 17)); end
            checks++; if (if_c.dout !== (e < 17) || if_c.dout_n !== (e >= 17)) begin errors++; $display("FAIL rl1_dout edge %0d got %b/%b exp %b", e, if_c.dout, if_c.dout_n, (e < 17)); end
            checks++; if (if_c.busy !== ((e >= 2) && (e <= 16))) begin errors++; $display("FAIL rl1_busy edge %0d got %b exp %b", e, if_c.busy, ((e >= 2) && (e <= 16))); end
            $display("rl1: edge %0d busy=%b dout=%b fall=%b", e, if_c.busy, if_c.dout, if_c.fall_pulse);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        rst_n_c = 1'b0;
        if_a.din_async = 1'b0;
        if_b.din_async = 1'b0;
        if_c.din_async = 1'b0;
        test_reset;
        test_glitch;
        test_rise;
        test_bounce_fall;
        test_reset_mid_wait;
        test_back_to_back;
        test_fast;
        test_reset_level_high;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
